// File: rtl/hyp_mmio_pkg.sv
// Shared definitions for the hypotenuse accelerator MMIO front end:
// register offsets, STATUS/CTRL bit positions and issue FSM states.
package hyp_mmio_pkg;

  localparam logic [1:0] ADDR_OPERANDS = 2'd0;
  localparam logic [1:0] ADDR_RESULT   = 2'd1;
  localparam logic [1:0] ADDR_STATUS   = 2'd2;
  localparam logic [1:0] ADDR_CTRL     = 2'd3;

  localparam int ST_BUSY        = 0;
  localparam int ST_IN_FULL     = 1;
  localparam int ST_OUT_EMPTY   = 2;
  localparam int ST_OVF         = 3;
  localparam int ST_UDF         = 4;
  localparam int ST_IN_CNT_LSB  = 8;
  localparam int ST_OUT_CNT_LSB = 12;

  localparam int CTRL_CLR   = 0;
  localparam int CTRL_FLUSH = 1;
  localparam int CTRL_IE    = 2;

  // FIFO occupancy fits a STATUS nibble for every legal DEPTH (2..8)
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_HOLDOFF,
    S_IDLE,
    S_ISSUE,
    S_RELEASE
  } hyp_state_e;

endpackage

// File: rtl/hyp_sync_fifo.sv
// Synchronous FIFO with flush; push is ignored when full, pop when empty.
// Push and pop may happen together while non-empty.
module hyp_sync_fifo
  import hyp_mmio_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/hyp_mmio_ctrl.sv
// CPU-facing MMIO front end: queues operand pairs, issues them to the
// hypotenuse unit via start/ready/release, and queues results for loads.
module hyp_mmio_ctrl
  import hyp_mmio_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int HOLDOFF = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [1:0]  addr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  input  logic        re_i,
  output logic [31:0] rdata_o,
  output logic        hyp_start_o,
  output logic [7:0]  hyp_a_o,
  output logic [7:0]  hyp_b_o,
  input  logic [8:0]  hyp_c_i,
  input  logic        hyp_ready_i,
  output logic        irq_o
);

  localparam int HW = $clog2(HOLDOFF + 1);

  hyp_state_e       state_q, state_d;
  logic [HW-1:0]    cnt_q, cnt_d;
  logic             discard_q, discard_d;
  logic             start_d;
  logic [7:0]       a_d, b_d;

  logic             wr_op, wr_ctrl, rd_res, flush;
  logic             in_pop, in_full, in_empty;
  logic             out_push, out_full, out_empty;
  logic [15:0]      in_head;
  logic [8:0]       out_head;
  logic [CNT_W-1:0] in_count, out_count;
  logic             ovf_q, udf_q, ie_q;
  logic [31:0]      status;
  logic             unused_wdata;

  assign wr_op        = we_i && (addr_i == ADDR_OPERANDS);
  assign wr_ctrl      = we_i && (addr_i == ADDR_CTRL);
  assign rd_res       = re_i && (addr_i == ADDR_RESULT);
  assign flush        = wr_ctrl && wdata_i[CTRL_FLUSH];
  assign unused_wdata = ^wdata_i[31:16];

  hyp_sync_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_in_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (wr_op),
    .pop   (in_pop),
    .flush (flush),
    .wdata (wdata_i[15:0]),
    .rdata (in_head),
    .full  (in_full),
    .empty (in_empty),
    .count (in_count)
  );

  hyp_sync_fifo #(.WIDTH(9), .DEPTH(DEPTH)) u_out_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (out_push),
    .pop   (rd_res),
    .flush (flush),
    .wdata (hyp_c_i),
    .rdata (out_head),
    .full  (out_full),
    .empty (out_empty),
    .count (out_count)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_HOLDOFF;
      cnt_q       <= HW'(HOLDOFF - 1);
      discard_q   <= 1'b0;
      hyp_start_o <= 1'b0;
      hyp_a_o     <= '0;
      hyp_b_o     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      discard_q   <= discard_d;
      hyp_start_o <= start_d;
      hyp_a_o     <= a_d;
      hyp_b_o     <= b_d;
    end
  end

  // Issue only with output room reserved, so a returning result always fits.
  // A flush during ISSUE marks the in-flight result for discard.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    discard_d = discard_q;
    start_d   = hyp_start_o;
    a_d       = hyp_a_o;
    b_d       = hyp_b_o;
    in_pop    = 1'b0;
    out_push  = 1'b0;
    case (state_q)
      S_HOLDOFF: begin
        start_d = 1'b0;
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - HW'(1);
      end
      S_IDLE: begin
        if (!in_empty && !out_full && !flush) begin
          in_pop    = 1'b1;
          a_d       = in_head[7:0];
          b_d       = in_head[15:8];
          start_d   = 1'b1;
          discard_d = 1'b0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (flush) discard_d = 1'b1;
        if (hyp_ready_i) begin
          out_push  = !discard_q && !flush;
          start_d   = 1'b0;
          discard_d = 1'b0;
          state_d   = S_RELEASE;
        end
      end
      S_RELEASE: begin
        start_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_HOLDOFF;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      ie_q  <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ie_q <= wdata_i[CTRL_IE];
        if (wdata_i[CTRL_CLR]) begin
          ovf_q <= 1'b0;
          udf_q <= 1'b0;
        end
      end
      if (wr_op && in_full)    ovf_q <= 1'b1;
      if (rd_res && out_empty) udf_q <= 1'b1;
    end
  end

  always_comb begin
    status                                 = '0;
    status[ST_BUSY]                        = (state_q != S_IDLE);
    status[ST_IN_FULL]                     = in_full;
    status[ST_OUT_EMPTY]                   = out_empty;
    status[ST_OVF]                         = ovf_q;
    status[ST_UDF]                         = udf_q;
    status[ST_IN_CNT_LSB +: CNT_W]         = in_count;
    status[ST_OUT_CNT_LSB +: CNT_W]        = out_count;
  end

  always_comb begin
    rdata_o = '0;
    case (addr_i)
      ADDR_RESULT: rdata_o = out_empty ? 32'h0 : {1'b1, 22'b0, out_head};
      ADDR_STATUS: rdata_o = status;
      ADDR_CTRL:   rdata_o = {29'b0, ie_q, 2'b0};
      default:     rdata_o = '0;
    endcase
  end

  assign irq_o = ie_q && !out_empty;

endmodule
